// File: rtl/rf_mp.sv
// rf_mp: NR-read/NW-write register file with bypass, optional zero R0 and busy scoreboard (in: wd/waddr/write, ra/read, resv/resv_addr; out: q, qbusy, busy)
module rf_mp #(
  parameter int M = 3,
  parameter int N = 8,
  parameter int NR = 2,
  parameter int NW = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW*N-1:0]  wd,
  input  logic [NW*M-1:0]  waddr,
  input  logic [NW-1:0]    write,
  input  logic [NR*M-1:0]  ra,
  input  logic [NR-1:0]    read,
  output logic [NR*N-1:0]  q,
  output logic [NR-1:0]    qbusy,
  input  logic             resv,
  input  logic [M-1:0]     resv_addr,
  output logic [2**M-1:0]  busy
);
  localparam int D = 2**M;
  logic [N-1:0] mem_q [D];
  logic [N-1:0] mem_d [D];
  logic [D-1:0] hit, busy_q, busy_d;
  logic [NR*N-1:0] q_q, q_d;
  logic [NR-1:0] qbusy_q, qbusy_d;
  always_comb begin
    for (int k = 0; k < D; k++) mem_d[k] = mem_q[k];
    hit = '0;
    for (int j = 0; j < NW; j++)
      if (write[j] && !(ZERO_R0 != 0 && waddr[j*M +: M] == '0)) begin
        mem_d[waddr[j*M +: M]] = wd[j*N +: N];
        hit[waddr[j*M +: M]] = 1'b1;
      end
    for (int k = 0; k < D; k++) busy_d[k] = (resv && resv_addr == M'(k)) || (busy_q[k] && !hit[k]);
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end
  always_comb begin
    q_d = '0;
    qbusy_d = '0;
    for (int i = 0; i < NR; i++)
      if (read[i] && !(ZERO_R0 != 0 && ra[i*M +: M] == '0)) begin
        q_d[i*N +: N] = BYPASS != 0 ? mem_d[ra[i*M +: M]] : mem_q[ra[i*M +: M]];
        qbusy_d[i] = BYPASS != 0 ? busy_d[ra[i*M +: M]] : busy_q[ra[i*M +: M]];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < D; k++) mem_q[k] <= '0;
      busy_q <= '0;
      q_q <= '0;
      qbusy_q <= '0;
    end else begin
      for (int k = 0; k < D; k++) mem_q[k] <= mem_d[k];
      busy_q <= busy_d;
      q_q <= q_d;
      qbusy_q <= qbusy_d;
    end
  assign q = q_q;
  assign qbusy = qbusy_q;
  assign busy = busy_q;
endmodule
